// File: rtl/a1_scaler.sv
// rtl/a1_scaler.sv - binary F-scaler chain with F-pulses, wrap carry and sticky SCAFAL watchdog
// Optional SCALER_PRESET_EN adds PRESET_LD/PRESET_VAL for loading the stage count directly.
module a1_scaler #(
   parameter int NSTAGES     = 32,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic               SIM_CLK,
   input  logic               RESET_,
   input  logic               F01A,
   input  logic               SCAINH,
`ifdef SCALER_PRESET_EN
   input  logic               PRESET_LD,
   input  logic [NSTAGES-1:0] PRESET_VAL,
`endif
   output logic [NSTAGES-1:0] FS,
   output logic [NSTAGES-1:0] FP,
   output logic               CARRY,
   output logic               SCAFAL
);

   localparam int IW = $clog2(WDOG_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(WDOG_CYCLES);
   localparam logic [IW-1:0] IDLE_LAST = IW'(WDOG_CYCLES - 1);

   logic [NSTAGES-1:0] fs_inc;
   logic [NSTAGES-1:0] fs_next;
   logic [NSTAGES-1:0] fp_next;
   logic               carry_next;
   logic               advance;
   logic [IW-1:0]      idle_cnt;
   logic [IW-1:0]      idle_next;
   logic               scafal_next;

   assign advance = F01A & ~SCAINH;
   assign fs_inc  = FS + NSTAGES'(1);

   // Stages that rise on this update pulse; a wrap rises nothing and carries instead.
   always_comb begin
      fs_next    = FS;
      fp_next    = '0;
      carry_next = 1'b0;
`ifdef SCALER_PRESET_EN
      if (PRESET_LD) begin
         fs_next = PRESET_VAL;
      end else
`endif
      if (advance) begin
         fs_next    = fs_inc;
         fp_next    = fs_inc & ~FS;
         carry_next = &FS;
      end
   end

   // Inhibited strobes still prove the timer is alive, so the watchdog looks at raw F01A.
   always_comb begin
      idle_next   = idle_cnt;
      scafal_next = SCAFAL;
      if (F01A) begin
         idle_next = '0;
      end else if (idle_cnt != IDLE_MAX) begin
         idle_next = idle_cnt + IW'(1);
         if (idle_cnt == IDLE_LAST) begin
            scafal_next = 1'b1;
         end
      end
   end

   always_ff @(posedge SIM_CLK) begin
      if (!RESET_) begin
         FS       <= '0;
         FP       <= '0;
         CARRY    <= 1'b0;
         SCAFAL   <= 1'b0;
         idle_cnt <= '0;
      end else begin
         FS       <= fs_next;
         FP       <= fp_next;
         CARRY    <= carry_next;
         SCAFAL   <= scafal_next;
         idle_cnt <= idle_next;
      end
   end

endmodule

// File: tb/tb_a1_scaler.sv
// tb/tb_a1_scaler.sv - directed self-checking bench for a1_scaler (NSTAGES=4, WDOG_CYCLES=8)
module tb_a1_scaler;

   localparam int NS = 4;

   logic          SIM_CLK = 1'b0;
   logic          RESET_  = 1'b0;
   logic          F01A    = 1'b0;
   logic          SCAINH  = 1'b0;
   logic [NS-1:0] FS;
   logic [NS-1:0] FP;
   logic          CARRY;
   logic          SCAFAL;
`ifdef SCALER_PRESET_EN
   logic          PRESET_LD  = 1'b0;
   logic [NS-1:0] PRESET_VAL = '0;
`endif

   int n_pass  = 0;
   int n_total = 0;

   a1_scaler #(.NSTAGES(NS), .WDOG_CYCLES(8)) dut (
      .SIM_CLK    (SIM_CLK),
      .RESET_     (RESET_),
      .F01A       (F01A),
      .SCAINH     (SCAINH),
`ifdef SCALER_PRESET_EN
      .PRESET_LD  (PRESET_LD),
      .PRESET_VAL (PRESET_VAL),
`endif
      .FS         (FS),
      .FP         (FP),
      .CARRY      (CARRY),
      .SCAFAL     (SCAFAL)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge SIM_CLK);
      #1;
   endtask

   task automatic pulse();
      F01A = 1'b1;
      tick();
      F01A = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      check("rst_fs", 32'(FS), 0);
      check("rst_fp", 32'(FP), 0);
      check("rst_carry", 32'(CARRY), 0);
      check("rst_scafal", 32'(SCAFAL), 0);

      RESET_ = 1'b1;
      tick();
      pulse();
      check("first_fs", 32'(FS), 1);
      check("first_fp", 32'(FP), 1);
      check("first_carry", 32'(CARRY), 0);
      tick();
      check("first_fp_one_cycle", 32'(FP), 0);
      check("first_fs_hold", 32'(FS), 1);

      pulse();
      check("fs2", 32'(FS), 2);
      check("fp2", 32'(FP), 2);
      tick();
      pulse();
      check("fs3", 32'(FS), 3);
      check("fp3", 32'(FP), 1);
      tick();
      pulse();
      check("fs4", 32'(FS), 4);
      check("fp4", 32'(FP), 4);
      tick();

      for (int i = 0; i < 11; i++) begin
         pulse();
         tick();
      end
      check("pre_wrap_fs", 32'(FS), 15);
      pulse();
      check("wrap_fs", 32'(FS), 0);
      check("wrap_fp", 32'(FP), 0);
      check("wrap_carry", 32'(CARRY), 1);
      tick();
      check("carry_one_cycle", 32'(CARRY), 0);

      F01A = 1'b1;
      tick();
      check("back2back_fs1", 32'(FS), 1);
      tick();
      check("back2back_fs2", 32'(FS), 2);
      check("back2back_fp2", 32'(FP), 2);
      tick();
      check("back2back_fs3", 32'(FS), 3);
      check("back2back_fp3", 32'(FP), 1);
      F01A = 1'b0;
      tick();

      SCAINH = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pulse();
         check("inh_fs", 32'(FS), 3);
         check("inh_fp", 32'(FP), 0);
         check("inh_carry", 32'(CARRY), 0);
         tick();
      end
      check("inh_scafal", 32'(SCAFAL), 0);
      SCAINH = 1'b0;
      pulse();
      check("uninh_fs", 32'(FS), 4);
      check("uninh_fp", 32'(FP), 4);

      repeat (7) tick();
      check("wdog_7idle", 32'(SCAFAL), 0);
      pulse();
      check("wdog_after_pulse", 32'(SCAFAL), 0);
      repeat (7) tick();
      check("wdog_7of8", 32'(SCAFAL), 0);
      tick();
      check("wdog_trip", 32'(SCAFAL), 1);
      pulse();
      check("wdog_sticky1", 32'(SCAFAL), 1);
      pulse();
      check("wdog_sticky2", 32'(SCAFAL), 1);

      RESET_ = 1'b0;
      F01A   = 1'b1;
      tick();
      check("midrst_fs", 32'(FS), 0);
      check("midrst_fp", 32'(FP), 0);
      check("midrst_scafal", 32'(SCAFAL), 0);
      F01A   = 1'b0;
      RESET_ = 1'b1;
      tick();
      pulse();
      check("postrst_fs", 32'(FS), 1);
      check("postrst_fp", 32'(FP), 1);
      tick();

`ifdef SCALER_PRESET_EN
      PRESET_LD  = 1'b1;
      PRESET_VAL = 4'hE;
      F01A       = 1'b1;
      tick();
      PRESET_LD  = 1'b0;
      F01A       = 1'b0;
      check("preset_fs", 32'(FS), 32'hE);
      check("preset_fp", 32'(FP), 0);
      check("preset_carry", 32'(CARRY), 0);
      tick();
      pulse();
      check("preset_fs_f", 32'(FS), 32'hF);
      check("preset_fp_f", 32'(FP), 1);
      tick();
      pulse();
      check("preset_wrap_fs", 32'(FS), 0);
      check("preset_wrap_carry", 32'(CARRY), 1);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
